// File: rtl/down_counter_timer_pkg.sv
// Shared counter definitions: FSM state encoding and default counter width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package down_counter_timer_pkg;

  // Default counter width, kept in step with the up-counter.
  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/down_counter_timer.sv
// Loadable down-counter/timer: counts a programmed value to zero, pulses tc, optional auto-reload.
// Latency: q reaches 0 (tc=1) on the load_value-th edge after start, DONE the edge after.
// Backpressure: none; stop pauses the count with q held and a later start resumes.
//
// Ports:
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   load, load_value     capture load_value into q and the reload register, go IDLE
//   start, stop          begin/resume and pause counting (stop wins if both)
//   auto_reload          at zero in RUN, reload and keep running instead of finishing
//   q, tc, busy, done    count, terminal-count pulse, RUN flag, sticky completion flag
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy,
  output logic             done
);

  state_t           state;
  logic [WIDTH-1:0] reload;

  // Both flags are pure decodes of the registered state, so they stay glitch-free.
  assign busy = (state == RUN);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q      <= '0;
      reload <= '0;
      state  <= IDLE;
      tc     <= 1'b0;
    end else begin
      // tc is a single-cycle pulse; only the 1->0 transition raises it.
      tc <= 1'b0;
      if (load) begin
        q      <= load_value;
        reload <= load_value;
        state  <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            // A zero count has nothing to time, so start is ignored.
            if (!stop && start && (q != '0)) begin
              state <= RUN;
            end
          end
          RUN: begin
            if (stop) begin
              state <= IDLE;
            end else if (q != '0) begin
              q  <= q - WIDTH'(1);
              tc <= (q == WIDTH'(1));
            end else if (auto_reload && (reload != '0)) begin
              // Zero is held for one cycle before reloading: period = reload + 1.
              q <= reload;
            end else begin
              state <= DONE;
            end
          end
          DONE: begin
            // q is already 0 here; stop is a no-op and blocks a same-edge start.
            if (!stop && start && (reload != '0)) begin
              q     <= reload;
              state <= RUN;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule
